// File: rtl/clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : clock_display_scan
// Brief    : Six-digit multiplexed 7-segment scanner for HH.MM.SS with a
//            per-frame snapshot. Optional adjust-field blinking is enabled by
//            defining CLOCK_DISPLAY_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clock_display_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic [7:0] hour,
   input  logic [7:0] minute,
   input  logic [7:0] second,
   input  logic [1:0] sel,
   output logic [7:0] seg,
   output logic [5:0] dig
);

   localparam logic [15:0] c_prescale_last = 16'(SCAN_DIV - 1);
   localparam logic [2:0]  c_last_digit    = 3'd5;

   logic [15:0] r_prescale;
   logic [2:0]  r_index;
   logic [7:0]  r_hour_snap;
   logic [7:0]  r_minute_snap;
   logic [7:0]  r_second_snap;
   logic [7:0]  r_seg;
   logic [5:0]  r_dig;

   logic        w_tc;
   logic        w_frame_start;
   logic [7:0]  w_value;
   logic [7:0]  w_digit_value;
   logic [6:0]  w_pattern;
   logic        w_dp_n;
   logic        w_blank;
   logic [7:0]  w_seg;
   logic [5:0]  w_dig;

   assign w_tc          = (r_prescale == c_prescale_last);
   assign w_frame_start = w_tc && (r_index == c_last_digit);

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_prescale <= '0;
         r_index    <= c_last_digit;
      end else begin
         r_prescale <= w_tc ? '0 : r_prescale + 16'd1;
         if (w_tc) begin
            r_index <= (r_index == c_last_digit) ? 3'd0 : r_index + 3'd1;
         end
      end
   end

   // Inputs are frozen for a whole frame so a field never tears across digits.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_hour_snap   <= '0;
         r_minute_snap <= '0;
         r_second_snap <= '0;
      end else if (w_frame_start) begin
         r_hour_snap   <= hour;
         r_minute_snap <= minute;
         r_second_snap <= second;
      end
   end

   always_comb begin
      case (r_index)
         3'd0, 3'd1: w_value = r_hour_snap;
         3'd2, 3'd3: w_value = r_minute_snap;
         default:    w_value = r_second_snap;
      endcase
   end

   assign w_digit_value = r_index[0] ? (w_value % 8'd10) : (w_value / 8'd10);

   always_comb begin
      w_pattern = 7'h3F;
      if (w_value <= 8'd99) begin
         case (w_digit_value)
            8'd0:    w_pattern = 7'h40;
            8'd1:    w_pattern = 7'h79;
            8'd2:    w_pattern = 7'h24;
            8'd3:    w_pattern = 7'h30;
            8'd4:    w_pattern = 7'h19;
            8'd5:    w_pattern = 7'h12;
            8'd6:    w_pattern = 7'h02;
            8'd7:    w_pattern = 7'h78;
            8'd8:    w_pattern = 7'h00;
            8'd9:    w_pattern = 7'h10;
            default: w_pattern = 7'h7F;
         endcase
      end
   end

   // Decimal points separate HH.MM.SS, so they sit on the hour and minute units.
   assign w_dp_n = !((r_index == 3'd1) || (r_index == 3'd3));

`ifdef CLOCK_DISPLAY_BLINK_EN
   localparam logic [7:0] c_blink_frames = 8'(BLINK_FRAMES);

   logic [1:0] r_sel_snap;
   logic [7:0] r_frame_cnt;
   logic       r_phase;
   logic [1:0] w_field;

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_sel_snap  <= '0;
         r_frame_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (w_frame_start) begin
         r_sel_snap <= sel;
         if (r_frame_cnt == c_blink_frames) begin
            r_frame_cnt <= 8'd1;
            r_phase     <= ~r_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      case (r_index)
         3'd0, 3'd1: w_field = 2'b01;
         3'd2, 3'd3: w_field = 2'b10;
         default:    w_field = 2'b11;
      endcase
   end

   assign w_blank = r_phase && (r_sel_snap != 2'b00) && (r_sel_snap == w_field);
`else
   logic w_sel_unused;
   assign w_sel_unused = ^sel;
   assign w_blank      = 1'b0;
`endif

   assign w_seg = w_blank ? 8'hFF : {w_dp_n, w_pattern};
   assign w_dig = ~(6'd1 << r_index);

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_seg <= 8'hFF;
         r_dig <= 6'h3F;
      end else begin
         r_seg <= w_seg;
         r_dig <= w_dig;
      end
   end

   assign seg = r_seg;
   assign dig = r_dig;

endmodule
`default_nettype wire

// File: tb/tb_clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_display_scan
// Brief    : Self-checking bench for clock_display_scan against a timing model
//            derived from edge counts since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_display_scan;

   localparam int SCAN_DIV     = 4;
   localparam int BLINK_FRAMES = 2;

   logic       clk    = 1'b0;
   logic       RESET  = 1'b1;
   logic [7:0] hour   = 8'd0;
   logic [7:0] minute = 8'd0;
   logic [7:0] second = 8'd0;
   logic [1:0] sel    = 2'b00;
   logic [7:0] seg;
   logic [5:0] dig;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: edges since release, frame snapshot, frames started.
   int k;
   int snap_h, snap_m, snap_s, snap_sel;
   int frames;
   int cur_d;

   logic [7:0] dec [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   clock_display_scan #(
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk    (clk),
      .RESET  (RESET),
      .hour   (hour),
      .minute (minute),
      .second (second),
      .sel    (sel),
      .seg    (seg),
      .dig    (dig)
   );

   always #5 clk = ~clk;

   // Digit enabled after edge j (j counted from reset release).
   function automatic int idx_at(input int j);
      if (j < SCAN_DIV) return 5;
      return ((j / SCAN_DIV) - 1) % 6;
   endfunction

   function automatic logic [7:0] exp_seg(input int d);
      int         v;
      int         digit;
      logic [7:0] s;
      bit         blank;
      v = (d < 2) ? snap_h : ((d < 4) ? snap_m : snap_s);
      blank = 1'b0;
`ifdef CLOCK_DISPLAY_BLINK_EN
      blank = (((frames - 1) / BLINK_FRAMES) % 2 == 1) && (snap_sel != 0)
              && (snap_sel == d / 2 + 1);
`endif
      if (v > 99) begin
         s = 8'hBF;
      end else begin
         digit = (d % 2 == 1) ? v % 10 : v / 10;
         s = dec[digit];
      end
      if (d == 1 || d == 3) s[7] = 1'b0;
      if (blank) s = 8'hFF;
      return s;
   endfunction

   task automatic check(input string tag, input logic [7:0] s_exp, input logic [5:0] d_exp);
      vectors++;
      assert (seg === s_exp) else begin
         miscompares++;
         $error("FAIL %s seg: observed %h expected %h (t=%0t)", tag, seg, s_exp, $time);
      end
      vectors++;
      assert (dig === d_exp) else begin
         miscompares++;
         $error("FAIL %s dig: observed %h expected %h (t=%0t)", tag, dig, d_exp, $time);
      end
   endtask

   task automatic model_reset();
      k        = 0;
      snap_h   = 0;
      snap_m   = 0;
      snap_s   = 0;
      snap_sel = 0;
      frames   = 0;
      cur_d    = 5;
   endtask

   task automatic step(input string tag);
      logic [7:0] s_exp;
      logic [5:0] d_exp;
      @(posedge clk);
      k++;
      cur_d = idx_at(k - 1);
      s_exp = exp_seg(cur_d);
      d_exp = 6'h3F;
      d_exp[cur_d] = 1'b0;
      if (k >= SCAN_DIV && (k % SCAN_DIV) == 0 && idx_at(k) == 0) begin
         snap_h   = int'(hour);
         snap_m   = int'(minute);
         snap_s   = int'(second);
         snap_sel = int'(sel);
         frames++;
      end
      #1;
      check(tag, s_exp, d_exp);
   endtask

   task automatic wait_digit(input int d);
      for (int i = 0; i < 100 && cur_d != d; i++) step("align");
   endtask

   initial begin
      model_reset();
      #1 RESET = 1'b0;
      #2 check("reset_async", 8'hFF, 6'h3F);
      @(posedge clk);
      #1 check("reset_hold", 8'hFF, 6'h3F);

      hour   = 8'd23;
      minute = 8'd59;
      second = 8'd7;
      RESET  = 1'b1;
      model_reset();
      repeat (SCAN_DIV * 6 * 2 + 6) step("basic_frame");

      hour = 8'd12;
      wait_digit(0);
      wait_digit(2);
      hour = 8'd13;
      repeat (SCAN_DIV * 6 * 2) step("no_tear");

      minute = 8'd100;
      second = 8'd255;
      repeat (SCAN_DIV * 6 * 2) step("dash");

      hour   = 8'd5;
      minute = 8'd45;
      second = 8'd0;
      sel    = 2'b10;
      repeat (SCAN_DIV * 6 * 5) step("blink_min");
      sel    = 2'b01;
      repeat (SCAN_DIV * 6 * 8) step("blink_hour");

      repeat (700) begin
         if ($urandom_range(0, 7) == 0) hour   = 8'($urandom_range(0, 130));
         if ($urandom_range(0, 7) == 0) minute = 8'($urandom_range(0, 130));
         if ($urandom_range(0, 7) == 0) second = 8'($urandom_range(0, 130));
         if ($urandom_range(0, 31) == 0) sel   = 2'($urandom_range(0, 3));
         step("random");
      end

      wait_digit(3);
      RESET = 1'b0;
      #1 check("reset_mid", 8'hFF, 6'h3F);
      repeat (2) begin
         @(posedge clk);
         #1 check("reset_mid_hold", 8'hFF, 6'h3F);
      end
      hour   = 8'($urandom_range(0, 99));
      minute = 8'($urandom_range(0, 99));
      second = 8'($urandom_range(0, 99));
      RESET  = 1'b1;
      model_reset();
      repeat (SCAN_DIV * 6 * 2 + 8) step("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each digit stays enabled; legal 2..65535.
REQ-002 Parameter BLINK_FRAMES, default 64: full 6-digit frames per blink half-period; legal 1..255.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port RESET  input  1: asynchronous, active-low reset.
REQ-005 Port hour  input  8: binary hour value from the hour counter; valid display range 0..99.
REQ-006 Port minute  input  8: binary minute value; valid display range 0..99.
REQ-007 Port second  input  8: binary second value; valid display range 0..99.
REQ-008 Port sel  input  2: field under adjustment. 00 none, 01 hour, 10 minute, 11 second.
REQ-009 Port seg  output  8: active-low segments. seg[0..6] drive a..g; seg[7] drives dp.
REQ-010 Port dig  output  6: active-low digit enables. dig[0] is hour tens; dig[5] is second units.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; wrap cycle = terminal count (TC).
REQ-012 Digit index SHALL advance on TC: 0,1,2,3,4,5,0; no other values.
REQ-013 On TC with index 5->0, hour/minute/second SHALL be captured into snapshot registers; within a frame all digits SHALL show the snapshot only (no tearing).
REQ-014 Digit mapping: 0/1 hour tens/units, 2/3 minute tens/units, 4/5 second tens/units; tens = v/10, units = v%10 for v<=99.
REQ-015 Field value >99: both digits of that field SHALL show dash (g only, seg[6:0]=7'h3F).
REQ-016 Decode (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 hex.
REQ-017 dp (seg[7]=0) SHALL be lit on digits 1 and 3 only; all other digits SHALL have seg[7]=1.
REQ-018 seg and dig SHALL be registered and reflect the new index on the clock edge after the index changes (1-cycle latency).
REQ-019 Exactly one dig bit SHALL be low outside reset; no cycle with two digits enabled.
REQ-020 Leading zeros SHALL be displayed (hour 5 -> "05").

Reset
REQ-021 RESET low SHALL immediately force seg=8'hFF and dig=6'h3F, regardless of clk.
REQ-022 Reset values: prescaler 0, index 5, snapshots 0, frame counter 0, blink phase 0.
REQ-023 After release, first TC SHALL wrap index to 0 and take a snapshot; digit 0 enables one cycle later.
REQ-024 Reset mid-frame SHALL abandon the frame; no partial-frame state survives.

Configuration
REQ-025 Macro CLOCK_DISPLAY_BLINK_EN defined: frame counter counts index 5->0 wraps; blink phase toggles every BLINK_FRAMES frames.
REQ-026 With CLOCK_DISPLAY_BLINK_EN, when phase=1 and sel!=00, both digits of the selected field SHALL output seg=8'hFF, including dp; dig scanning is unchanged.
REQ-027 sel SHALL be sampled with the snapshot at frame start; a mid-frame change takes effect next frame.
REQ-028 Without CLOCK_DISPLAY_BLINK_EN: sel ignored, no frame counter or phase logic, no blanking.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-029 hour=23, minute=59, second=7 after reset -> per frame seg sequence A4,30,92,10,C0,F8 with dig 3E,3D,3B,37,2F,1F, each held 4 cycles.
REQ-030 hour changed 12->13 while digit 2 is active -> rest of frame shows 12; next frame shows 1,3.
REQ-031 minute=100 -> digit 2 seg=BF, digit 3 seg=3F; hour and second digits unaffected.
REQ-032 BLINK_EN, sel=10, minute=45 -> frames 1-2 show digits 2,3 as 99,12; frames 3-4 show FF,FF with dig still 3B,37; then repeat.
REQ-033 RESET pulsed low while digit 3 active -> seg=FF, dig=3F same cycle; after release digit 0 enables 5 cycles later.
REQ-034 BLINK_EN undefined, sel=01 for 8 frames -> hour digits never blanked.
